// File: rtl/wombat_cmd_pkg.sv
// Shared types and protocol constants for the wombat command engine.
package wombat_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_DATA      = 4'd2,
        ST_WRITE     = 4'd3,
        ST_READ_REQ  = 4'd4,
        ST_READ_WAIT = 4'd5,
        ST_TX_SEND   = 4'd6,
        ST_TX_HOLD   = 4'd7,
        ST_TX_WAIT   = 4'd8
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h72;
    localparam logic [7:0] CMD_WRITE = 8'h77;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    function automatic logic is_rx_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/wombat_command_engine_if.sv
// Byte-stream, transmitter and register-block signals of the wombat command engine.
interface wombat_command_engine_if #(
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 4
);
    logic [7:0]              i_rx_data;
    logic                    i_rx_dv;
    logic [7:0]              o_tx_data;
    logic                    o_tx_dv;
    logic                    i_tx_busy;
    logic                    o_w_en;
    logic [8*ADDR_BYTES-1:0] o_w_addr;
    logic [8*DATA_BYTES-1:0] o_w_value;
    logic                    o_r_en;
    logic [8*ADDR_BYTES-1:0] o_r_addr;
    logic [8*DATA_BYTES-1:0] i_r_value;
    logic                    i_r_valid;
    logic                    o_busy;
    logic                    o_err;

    modport slave (
        input  i_rx_data, i_rx_dv, i_tx_busy, i_r_value, i_r_valid,
        output o_tx_data, o_tx_dv, o_w_en, o_w_addr, o_w_value,
               o_r_en, o_r_addr, o_busy, o_err
    );

    modport master (
        output i_rx_data, i_rx_dv, i_tx_busy, i_r_value, i_r_valid,
        input  o_tx_data, o_tx_dv, o_w_en, o_w_addr, o_w_value,
               o_r_en, o_r_addr, o_busy, o_err
    );
endinterface

// File: rtl/wombat_cmd_tx_serializer.sv
// Response serializer: holds 1..DATA_BYTES bytes and paces them out MSB first
// through the TX_SEND / TX_HOLD / TX_WAIT handshake with the transmitter.
module wombat_cmd_tx_serializer
    import wombat_cmd_pkg::*;
#(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_load,
    input  logic [8*DATA_BYTES-1:0] i_load_data,
    input  logic [3:0]              i_load_count,
    input  state_t                  i_state,
    input  logic                    i_tx_busy,
    output state_t                  o_next_state,
    output logic                    o_tx_dv,
    output logic [7:0]              o_tx_data
);
    localparam int DW = 8 * DATA_BYTES;

    logic [DW-1:0] r_buf;
    logic [3:0]    r_left;
    logic          w_send;

    // The strobe must land in the same cycle the transmitter reports idle.
    assign w_send    = (i_state == ST_TX_SEND) && !i_tx_busy;
    assign o_tx_dv   = w_send;
    assign o_tx_data = r_buf[DW-1 -: 8];

    // Byte buffer and remaining-byte counter
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_buf  <= '0;
            r_left <= 4'd0;
        end else if (i_load) begin
            r_buf  <= i_load_data;
            r_left <= i_load_count;
        end else if (w_send) begin
            r_buf  <= r_buf << 8;
            r_left <= r_left - 4'd1;
        end
    end

    // Transmit handshake sequencing
    always_comb begin
        o_next_state = i_state;
        case (i_state)
            ST_TX_SEND: begin
                if (i_tx_busy) begin
                    o_next_state = ST_TX_SEND;
                end else begin
                    o_next_state = ST_TX_HOLD;
                end
            end
            ST_TX_HOLD: o_next_state = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (i_tx_busy) begin
                    o_next_state = ST_TX_WAIT;
                end else if (r_left != 4'd0) begin
                    o_next_state = ST_TX_SEND;
                end else begin
                    o_next_state = ST_IDLE;
                end
            end
            default: o_next_state = i_state;
        endcase
    end

endmodule

// File: rtl/wombat_command_engine.sv
// Byte-stream read/write command decoder feeding a register block, with ACK/NAK/data responses.
// Optional inter-byte timeout enabled by defining WOMBAT_CMD_TIMEOUT_EN.
module wombat_command_engine
    import wombat_cmd_pkg::*;
#(
    parameter int ADDR_BYTES     = 1,
    parameter int DATA_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 43400
) (
    input  logic                  clk,
    input  logic                  i_reset,
    wombat_command_engine_if.slave bus
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;

    state_t        r_state;
    state_t        w_next;
    state_t        w_ser_next;
    logic          r_is_write;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_value;
    logic          r_w_en;
    logic [AW-1:0] r_w_addr;
    logic [DW-1:0] r_w_value;
    logic          r_r_en;
    logic [AW-1:0] r_r_addr;
    logic          r_err;

    logic          w_timeout;
    logic          w_nak;
    logic          w_drop;
    logic          w_addr_last;
    logic          w_data_last;
    logic          w_ser_load;
    logic [DW-1:0] w_ser_data;
    logic [3:0]    w_ser_count;
    logic [AW-1:0] w_addr_shift;
    logic [DW-1:0] w_value_shift;
    logic [DW-1:0] w_ack_word;
    logic [DW-1:0] w_nak_word;

    assign w_addr_shift  = (r_addr << 8) | AW'(bus.i_rx_data);
    assign w_value_shift = (r_value << 8) | DW'(bus.i_rx_data);
    assign w_addr_last   = (r_cnt == 4'(ADDR_BYTES - 1));
    assign w_data_last   = (r_cnt == 4'(DATA_BYTES - 1));
    assign w_drop        = bus.i_rx_dv && !is_rx_state(r_state);
    // Single-byte responses sit in the top byte so they leave first.
    assign w_ack_word    = DW'(RSP_ACK) << (DW - 8);
    assign w_nak_word    = DW'(RSP_NAK) << (DW - 8);

    // Receive FSM next-state and serializer load decisions
    always_comb begin
        w_next      = r_state;
        w_nak       = 1'b0;
        w_ser_load  = 1'b0;
        w_ser_data  = '0;
        w_ser_count = 4'd1;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_rx_dv && (bus.i_rx_data == CMD_READ || bus.i_rx_data == CMD_WRITE)) begin
                    w_next = ST_ADDR;
                end else if (bus.i_rx_dv) begin
                    w_next = ST_TX_SEND;
                    w_nak  = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus.i_rx_dv && w_addr_last) begin
                    w_next = r_is_write ? ST_DATA : ST_READ_REQ;
                end else if (bus.i_rx_dv) begin
                    w_next = ST_ADDR;
                end else if (w_timeout) begin
                    w_next = ST_TX_SEND;
                    w_nak  = 1'b1;
                end else begin
                    w_next = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus.i_rx_dv && w_data_last) begin
                    w_next = ST_WRITE;
                end else if (bus.i_rx_dv) begin
                    w_next = ST_DATA;
                end else if (w_timeout) begin
                    w_next = ST_TX_SEND;
                    w_nak  = 1'b1;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_WRITE: begin
                w_next     = ST_TX_SEND;
                w_ser_load = 1'b1;
                w_ser_data = w_ack_word;
            end
            ST_READ_REQ: w_next = ST_READ_WAIT;
            ST_READ_WAIT: begin
                if (bus.i_r_valid) begin
                    w_next      = ST_TX_SEND;
                    w_ser_load  = 1'b1;
                    w_ser_data  = bus.i_r_value;
                    w_ser_count = 4'(DATA_BYTES);
                end else if (w_timeout) begin
                    w_next = ST_TX_SEND;
                    w_nak  = 1'b1;
                end else begin
                    w_next = ST_READ_WAIT;
                end
            end
            ST_TX_SEND, ST_TX_HOLD, ST_TX_WAIT: w_next = w_ser_next;
            default: w_next = ST_IDLE;
        endcase
        if (w_nak) begin
            w_ser_load  = 1'b1;
            w_ser_data  = w_nak_word;
            w_ser_count = 4'd1;
        end else begin
            w_ser_count = w_ser_count;
        end
    end

    // State, frame assembly and registered strobes
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_is_write <= 1'b0;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_value    <= '0;
            r_w_en     <= 1'b0;
            r_w_addr   <= '0;
            r_w_value  <= '0;
            r_r_en     <= 1'b0;
            r_r_addr   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_w_en  <= (r_state == ST_DATA) && bus.i_rx_dv && w_data_last;
            r_r_en  <= (r_state == ST_ADDR) && bus.i_rx_dv && w_addr_last && !r_is_write;
            r_err   <= w_nak || w_drop;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_rx_dv) begin
                        r_is_write <= (bus.i_rx_data == CMD_WRITE);
                        r_cnt      <= 4'd0;
                        r_addr     <= '0;
                        r_value    <= '0;
                    end
                end
                ST_ADDR: begin
                    if (bus.i_rx_dv) begin
                        r_addr <= w_addr_shift;
                        r_cnt  <= w_addr_last ? 4'd0 : r_cnt + 4'd1;
                        if (w_addr_last && !r_is_write) begin
                            r_r_addr <= w_addr_shift;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.i_rx_dv) begin
                        r_value <= w_value_shift;
                        r_cnt   <= r_cnt + 4'd1;
                        if (w_data_last) begin
                            r_w_addr  <= r_addr;
                            r_w_value <= w_value_shift;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WOMBAT_CMD_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] r_to_cnt;

    // Idle-cycle counter for partial frames and outstanding reads
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_to_cnt <= '0;
        end else if (bus.i_rx_dv || (r_state == ST_READ_REQ) ||
                     !((r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_READ_WAIT))) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + TOW'(1);
        end
    end

    assign w_timeout = (r_to_cnt == TOW'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    wombat_cmd_tx_serializer #(
        .DATA_BYTES (DATA_BYTES)
    ) u_tx_ser (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_load       (w_ser_load),
        .i_load_data  (w_ser_data),
        .i_load_count (w_ser_count),
        .i_state      (r_state),
        .i_tx_busy    (bus.i_tx_busy),
        .o_next_state (w_ser_next),
        .o_tx_dv      (bus.o_tx_dv),
        .o_tx_data    (bus.o_tx_data)
    );

    assign bus.o_w_en    = r_w_en;
    assign bus.o_w_addr  = r_w_addr;
    assign bus.o_w_value = r_w_value;
    assign bus.o_r_en    = r_r_en;
    assign bus.o_r_addr  = r_r_addr;
    assign bus.o_err     = r_err;
    assign bus.o_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wombat_command_engine.sv
// Directed bench: default (1/4-byte) engine plus a 2/2-byte engine, each with
// a small register-block and transmitter model.
module tb_wombat_command_engine;
    import wombat_cmd_pkg::*;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic hold_busy = 1'b0;
    int   cyc       = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   last_rx   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wombat_command_engine_if #(.ADDR_BYTES(1), .DATA_BYTES(4)) bn ();
    wombat_command_engine_if #(.ADDR_BYTES(2), .DATA_BYTES(2)) bw ();

    wombat_command_engine #(.ADDR_BYTES(1), .DATA_BYTES(4), .TIMEOUT_CYCLES(1000))
        dut_n (.clk(clk), .i_reset(rst), .bus(bn.slave));
    wombat_command_engine #(.ADDR_BYTES(2), .DATA_BYTES(2), .TIMEOUT_CYCLES(1000))
        dut_w (.clk(clk), .i_reset(rst), .bus(bw.slave));

    // Register-block and transmitter models
    logic [31:0] mem_n [16];
    logic [15:0] mem_w [16];
    logic [3:0]  bcnt_n = 4'd0;
    logic [3:0]  bcnt_w = 4'd0;
    assign bn.i_tx_busy = (bcnt_n != 4'd0) || hold_busy;
    assign bw.i_tx_busy = (bcnt_w != 4'd0);

    always @(posedge clk) begin
        if (bn.o_w_en) mem_n[bn.o_w_addr[3:0]] <= bn.o_w_value;
        if (bw.o_w_en) mem_w[bw.o_w_addr[3:0]] <= bw.o_w_value;
        bn.i_r_valid <= bn.o_r_en;
        bn.i_r_value <= mem_n[bn.o_r_addr[3:0]];
        bw.i_r_valid <= bw.o_r_en;
        bw.i_r_value <= mem_w[bw.o_r_addr[3:0]];
        bcnt_n <= bn.o_tx_dv ? 4'd5 : ((bcnt_n != 4'd0) ? bcnt_n - 4'd1 : 4'd0);
        bcnt_w <= bw.o_tx_dv ? 4'd5 : ((bcnt_w != 4'd0) ? bcnt_w - 4'd1 : 4'd0);
    end

    // Output monitors, sampled mid-cycle
    int          wen_n = 0, ren_n = 0, err_n = 0, wen_cyc_n = 0, ren_cyc_n = 0;
    int          wen_w = 0, ren_w = 0;
    logic [7:0]  waddr_n = 8'd0, raddr_n = 8'd0;
    logic [31:0] wval_n = 32'd0;
    logic [15:0] waddr_w = 16'd0, raddr_w = 16'd0, wval_w = 16'd0;
    logic [7:0]  txq_n [$];
    int          txc_n [$];
    logic [7:0]  txq_w [$];

    always @(negedge clk) begin
        if (bn.o_w_en) begin
            wen_n <= wen_n + 1; wen_cyc_n <= cyc; waddr_n <= bn.o_w_addr; wval_n <= bn.o_w_value;
        end
        if (bn.o_r_en) begin
            ren_n <= ren_n + 1; ren_cyc_n <= cyc; raddr_n <= bn.o_r_addr;
        end
        if (bn.o_err) err_n <= err_n + 1;
        if (bn.o_tx_dv) begin
            txq_n.push_back(bn.o_tx_data); txc_n.push_back(cyc);
        end
        if (bw.o_w_en) begin
            wen_w <= wen_w + 1; waddr_w <= bw.o_w_addr; wval_w <= bw.o_w_value;
        end
        if (bw.o_r_en) begin
            ren_w <= ren_w + 1; raddr_w <= bw.o_r_addr;
        end
        if (bw.o_tx_dv) txq_w.push_back(bw.o_tx_data);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input bit wide, input logic [7:0] b);
        @(negedge clk);
        if (wide) begin
            bw.i_rx_data = b; bw.i_rx_dv = 1'b1;
        end else begin
            bn.i_rx_data = b; bn.i_rx_dv = 1'b1;
        end
        last_rx = cyc;
        @(negedge clk);
        bn.i_rx_dv = 1'b0;
        bw.i_rx_dv = 1'b0;
    endtask

    task automatic send_frame(input bit wide, input logic [7:0] b [6], input int n);
        for (int i = 0; i < n; i++) send_byte(wide, b[i]);
    endtask

    task automatic wait_idle(input bit wide, input string tag);
        int k = 0;
        while (((wide ? bw.o_busy : bn.o_busy) == 1'b1) && k < 300) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check_eq({tag, " idle"}, 64'(wide ? bw.o_busy : bn.o_busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int err0, wen0, rx03, min_gap;
        for (int i = 0; i < 16; i++) begin
            mem_n[i] = 32'd0;
            mem_w[i] = 16'd0;
        end
        bn.i_rx_data = 8'd0; bn.i_rx_dv = 1'b0;
        bw.i_rx_data = 8'd0; bw.i_rx_dv = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset busy", 64'(bn.o_busy), 64'd0);
        check_eq("reset outs", 64'({bn.o_w_en, bn.o_r_en, bn.o_tx_dv, bn.o_err}), 64'd0);
        check_eq("reset waddr/wval", 64'({bn.o_w_addr, bn.o_w_value}), 64'd0);
        rst = 1'b0;

        // Write 77 03 DE AD BE EF
        send_frame(1'b0, '{8'h77, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 6);
        wait_idle(1'b0, "write");
        check_eq("write count", 64'(wen_n), 64'd1);
        check_eq("write addr", 64'(waddr_n), 64'h03);
        check_eq("write value", 64'(wval_n), 64'hDEADBEEF);
        check_eq("write latency", 64'(wen_cyc_n), 64'(last_rx + 1));
        check_eq("ack count", 64'(txq_n.size()), 64'd1);
        check_eq("ack byte", 64'(txq_n[0]), 64'h06);
        check_eq("ack latency", 64'(txc_n[0]), 64'(wen_cyc_n + 1));
        check_eq("write no err", 64'(err_n), 64'd0);
        check_eq("waddr holds", 64'(bn.o_w_addr), 64'h03);

        // Read-back 72 03 with a stray byte arriving mid-response
        txq_n.delete(); txc_n.delete();
        err0 = err_n;
        send_byte(1'b0, 8'h72);
        send_byte(1'b0, 8'h03);
        rx03 = last_rx;
        send_byte(1'b0, 8'h55);
        wait_idle(1'b0, "read");
        check_eq("read count", 64'(ren_n), 64'd1);
        check_eq("read addr", 64'(raddr_n), 64'h03);
        check_eq("read latency", 64'(ren_cyc_n), 64'(rx03 + 1));
        check_eq("read bytes", 64'(txq_n.size()), 64'd4);
        check_eq("read data", 64'({txq_n[0], txq_n[1], txq_n[2], txq_n[3]}), 64'hDEADBEEF);
        check_eq("read tx latency", 64'(txc_n[0]), 64'(ren_cyc_n + 2));
        min_gap = 1000;
        for (int i = 1; i < txc_n.size(); i++)
            if (txc_n[i] - txc_n[i-1] < min_gap) min_gap = txc_n[i] - txc_n[i-1];
        check_eq("tx spacing >= 3", 64'(min_gap >= 3), 64'd1);
        check_eq("drop err", 64'(err_n - err0), 64'd1);
        check_eq("read no write", 64'(wen_n), 64'd1);

        // Bad command 41 while the transmitter is held busy
        txq_n.delete(); txc_n.delete();
        err0 = err_n;
        hold_busy = 1'b1;
        send_byte(1'b0, 8'h41);
        repeat (8) @(negedge clk);
        check_eq("nak held", 64'(txq_n.size()), 64'd0);
        check_eq("nak busy", 64'(bn.o_busy), 64'd1);
        @(posedge clk);
        #1 hold_busy = 1'b0;
        wait_idle(1'b0, "nak");
        check_eq("nak byte", 64'(txq_n.size() == 1 ? txq_n[0] : 8'hFF), 64'h15);
        check_eq("nak err", 64'(err_n - err0), 64'd1);

        // Valid write after the NAK
        txq_n.delete(); txc_n.delete();
        send_frame(1'b0, '{8'h77, 8'h07, 8'h00, 8'h00, 8'h01, 8'h02}, 6);
        wait_idle(1'b0, "write2");
        check_eq("write2 addr/val", 64'({waddr_n, wval_n}), 64'h07_00000102);
        check_eq("write2 ack", 64'(txq_n.size() == 1 ? txq_n[0] : 8'hFF), 64'h06);

        // Partial frame 77 05 11 left idle
        txq_n.delete(); txc_n.delete();
        err0 = err_n;
        wen0 = wen_n;
        send_frame(1'b0, '{8'h77, 8'h05, 8'h11, 8'h00, 8'h00, 8'h00}, 3);
        repeat (1100) @(negedge clk);
        check_eq("partial no write", 64'(wen_n), 64'(wen0));
`ifdef WOMBAT_CMD_TIMEOUT_EN
        check_eq("timeout idle", 64'(bn.o_busy), 64'd0);
        check_eq("timeout nak", 64'(txq_n.size() == 1 ? txq_n[0] : 8'hFF), 64'h15);
        check_eq("timeout err", 64'(err_n - err0), 64'd1);
        send_frame(1'b0, '{8'h77, 8'h05, 8'h11, 8'h00, 8'h00, 8'h00}, 3);
`else
        check_eq("no timeout busy", 64'(bn.o_busy), 64'd1);
        check_eq("no timeout tx", 64'(txq_n.size()), 64'd0);
`endif

        // Asynchronous reset in the middle of DATA
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midreset busy", 64'(bn.o_busy), 64'd0);
        check_eq("midreset outs", 64'({bn.o_w_en, bn.o_r_en, bn.o_tx_dv, bn.o_err, bn.o_tx_data}), 64'd0);
        check_eq("midreset waddr/wval", 64'({bn.o_w_addr, bn.o_w_value}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        txq_n.delete(); txc_n.delete();
        wen0 = wen_n;
        send_frame(1'b0, '{8'h77, 8'h05, 8'h00, 8'h00, 8'h00, 8'h2A}, 6);
        wait_idle(1'b0, "postreset");
        check_eq("postreset write", 64'(wen_n - wen0), 64'd1);
        check_eq("postreset addr/val", 64'({waddr_n, wval_n}), 64'h05_0000002A);
        check_eq("postreset ack", 64'(txq_n.size() == 1 ? txq_n[0] : 8'hFF), 64'h06);

        // Wide configuration: 2 address bytes, 2 value bytes
        send_frame(1'b1, '{8'h77, 8'h00, 8'h0A, 8'h12, 8'h34, 8'h00}, 5);
        wait_idle(1'b1, "wide write");
        check_eq("wide write", 64'({wen_w[7:0], waddr_w, wval_w}), 64'h01_000A_1234);
        check_eq("wide ack", 64'(txq_w.size() == 1 ? txq_w[0] : 8'hFF), 64'h06);
        txq_w.delete();
        send_frame(1'b1, '{8'h72, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00}, 3);
        wait_idle(1'b1, "wide read");
        check_eq("wide read addr", 64'({ren_w[7:0], raddr_w}), 64'h01_000A);
        check_eq("wide read bytes", 64'(txq_w.size()), 64'd2);
        check_eq("wide read data", 64'({txq_w[0], txq_w[1]}), 64'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
